// File: rtl/fifo_rd_ctrl_if.sv
// Read-side signal bundle for the async FIFO read controller.
// The slave side is the controller; the master side is the read agent plus the memory and synchronizer.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] aempty_value;
    logic [ADDR_WIDTH:0]   wq2_wptr_gray;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  rdempty;
    logic                  rd_almost_empty;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   fifo_read_count;
    logic [ADDR_WIDTH:0]   rd_level;

    modport slave (
        input  read_enable, aempty_value, wq2_wptr_gray, mem_rdata,
        output raddr, rptr_gray, read_data, rdempty, rd_almost_empty,
               underflow, fifo_read_count, rd_level
    );

    modport master (
        output read_enable, aempty_value, wq2_wptr_gray, mem_rdata,
        input  raddr, rptr_gray, read_data, rdempty, rd_almost_empty,
               underflow, fifo_read_count, rd_level
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain control: binary/Gray read pointer, registered read data,
// and empty / almost-empty / level status derived from the synchronized write pointer.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic          rclk,
    input  logic          hw_rst_n,
    input  logic          sw_rst,
    fifo_rd_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         r_rbin;
    logic [PW-1:0]         r_rgray;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdempty;
    logic                  r_aempty;
    logic                  r_underflow;
    logic [PW-1:0]         r_count;
    logic [PW-1:0]         r_level;

    logic                  w_rd_fire;
    logic [PW-1:0]         w_rbin_next;
    logic [PW-1:0]         w_rgray_next;
    logic [PW-1:0]         w_wbin_sync;
    logic [PW-1:0]         w_level_next;

    // Registered empty gates the read, so a read never races a pointer update.
    assign w_rd_fire    = bus.read_enable & ~r_rdempty;
    assign w_rbin_next  = r_rbin + PW'(w_rd_fire);
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);

    always_comb begin
        w_wbin_sync = '0;
        w_wbin_sync[PW-1] = bus.wq2_wptr_gray[PW-1];
        for (int i = PW - 2; i >= 0; i--)
            w_wbin_sync[i] = w_wbin_sync[i+1] ^ bus.wq2_wptr_gray[i];
    end

    // Modulo-64 difference; the extra pointer bit keeps full (32) distinct from empty (0).
    assign w_level_next = w_wbin_sync - w_rbin_next;

    always_ff @(posedge rclk) begin
        if (!hw_rst_n || sw_rst) begin
            r_rbin      <= '0;
            r_rgray     <= '0;
            r_rdata     <= '0;
            r_rdempty   <= 1'b1;
            r_aempty    <= 1'b1;
            r_underflow <= 1'b0;
            r_count     <= '0;
            r_level     <= '0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rgray     <= w_rgray_next;
            r_rdempty   <= (w_rgray_next == bus.wq2_wptr_gray);
            r_aempty    <= (w_level_next <= {1'b0, bus.aempty_value});
            r_underflow <= bus.read_enable & r_rdempty;
            r_level     <= w_level_next;
            if (w_rd_fire) begin
                r_rdata <= bus.mem_rdata;
                r_count <= r_count + PW'(1);
            end
        end
    end

    assign bus.raddr           = r_rbin[ADDR_WIDTH-1:0];
    assign bus.rptr_gray       = r_rgray;
    assign bus.read_data       = r_rdata;
    assign bus.rdempty         = r_rdempty;
    assign bus.rd_almost_empty = r_aempty;
    assign bus.underflow       = r_underflow;
    assign bus.fifo_read_count = r_count;
    assign bus.rd_level        = r_level;
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain control stage of the async FIFO, clocked on rclk.
- Sits directly upstream of the read-side signal set consumed by the read agent: produces read_data, rdempty, rd_almost_empty, underflow, fifo_read_count and rd_level from read_enable and aempty_value.
- Owns the binary/Gray read pointer, drives the memory read address, and converts the synchronized write pointer (from the 2-FF wclk->rclk synchronizer) into empty and level status.

Parameters:
- DATA_WIDTH, 32, read data width.
- ADDR_WIDTH, 5, memory address width; depth = 2^ADDR_WIDTH = 32; pointers are ADDR_WIDTH+1 bits.

Ports:
- rclk  input  1  read clock; all logic on posedge.
- hw_rst_n  input  1  synchronous active-low reset, sampled on posedge rclk.
- sw_rst  input  1  synchronous active-high flush; same effect as reset.
- read_enable  input  1  read request.
- aempty_value  input  5  almost-empty threshold (entries).
- wq2_wptr_gray  input  6  write pointer, Gray, already synchronized into rclk.
- mem_rdata  input  32  combinational memory read data at raddr.
- raddr  output  5  memory read address (rbin[4:0]).
- rptr_gray  output  6  registered Gray read pointer, to write-domain synchronizer.
- read_data  output  32  registered read data.
- rdempty  output  1  FIFO empty.
- rd_almost_empty  output  1  level <= aempty_value.
- underflow  output  1  one-cycle pulse on read attempt while empty.
- fifo_read_count  output  6  successful reads since reset, modulo 64.
- rd_level  output  6  entries available, 0..32.

Behaviour:
- Reset: hw_rst_n==0 or sw_rst==1 at a posedge sets rbin=0, rptr_gray=0, read_data=0, rdempty=1, rd_almost_empty=1, underflow=0, fifo_read_count=0, rd_level=0. hw_rst_n has priority; the two are otherwise equivalent. Reset mid-read discards the read; read_data is cleared.
- rd_fire = read_enable & ~rdempty, using the registered rdempty.
- On rd_fire:
  - read_data <= mem_rdata (value at current raddr); valid the cycle after read_enable is sampled, i.e. 1-cycle latency.
  - rbin <= rbin+1, wrapping 63->0.
  - fifo_read_count <= fifo_read_count+1, wrapping 63->0.
- No rd_fire: rbin, read_data and fifo_read_count hold.
- Gray: rbin_next = rbin + rd_fire; rgray_next = rbin_next ^ (rbin_next>>1); rptr_gray <= rgray_next. Exactly one bit changes per increment.
- Empty: rdempty <= (rgray_next == wq2_wptr_gray). Deassertion lags a write by the synchronizer delay, which is conservative and intended.
- Level:
  - wbin_sync = Gray-to-binary of wq2_wptr_gray.
  - rd_level <= (wbin_sync - rbin_next) mod 64; max 32 by construction.
- Almost empty: rd_almost_empty <= (level_next <= aempty_value), where level_next is the 6-bit value above compared zero-extended. aempty_value=0 makes it equivalent to empty.
- Underflow: underflow <= read_enable & rdempty.
  - The pointer, count and read_data do not change.
  - Held read_enable while empty gives an underflow pulse every cycle.
  - underflow is 0 in any cycle with rd_fire.
- Simultaneous last read and new write arrival: empty is computed from the post-read pointer against the current wq2_wptr_gray, so it asserts only if they match.
- Pointer wrap: after 32 reads the MSB toggles; empty and level stay correct across the 63->0 wrap.
- All outputs are registered; no combinational path from any input to any output except raddr = rbin[4:0].

Test Plan:
- Reset: hold hw_rst_n=0 for 2 cycles, release -> rdempty=1, rd_almost_empty=1, underflow=0, raddr=0, rptr_gray=0, rd_level=0, fifo_read_count=0.
- Basic read: wq2_wptr_gray=Gray(3)=6'b000010, mem model data 0xA0+addr, read_enable for 3 cycles -> read_data 0xA0, 0xA1, 0xA2 on consecutive cycles; rd_level 3->2->1->0; rdempty=1 after the third read; fifo_read_count=3.
- Underflow: FIFO empty, read_enable high 2 cycles -> underflow=1 for 2 cycles; raddr, read_data and fifo_read_count unchanged.
- Almost empty: aempty_value=4, level 6, read one per cycle -> rd_almost_empty=0 at levels 6,5; =1 at levels 4,3,2,1,0.
- Wrap: 40 writes presented via wq2_wptr_gray, 40 reads -> rbin passes 31->32 with rptr_gray MSB set, each rptr_gray step changes exactly 1 bit, rdempty=1 and rd_level=0 at the end, fifo_read_count=40.
- Flush mid-stream: level 10, reading; assert sw_rst for 1 cycle -> next cycle rbin=0, read_data=0, rdempty=1, fifo_read_count=0, underflow=0; no read occurs in the sw_rst cycle.
